// File: rtl/nrzi_decode.sv
// USB receive-path NRZI decoder.
// Recovers the original bit stream from the synchronized D+ level:
// a level change between bit periods decodes as 0, and no change decodes as 1.
// cur_q samples D+ every clock. prev_q holds the reference level and is
// re-latched only at the bit-sample strobe. An end-of-packet reloads the
// reference to the idle (J) level.
module nrzi_decode #(
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic shift_enable,
  input  logic eop,
  output logic d_orig
);

  logic d_in;
  logic cur_q,  cur_d;
  logic prev_q, prev_d;

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      // Delay line ahead of the sample register; stage 0 takes the raw line.
      always_comb begin
        sync_d[0] = d_plus;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      // Delay-line flops start at idle so the first decoded bits read as 1.
      always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
          sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
          sync_q <= sync_d;
        end
      end

      assign d_in = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign d_in = d_plus;
    end
  endgenerate

  // Next-state logic. The sample register follows the line every cycle.
  // The reference moves only on the strobe, and eop takes priority there.
  always_comb begin
    cur_d  = d_in;
    prev_d = prev_q;
    if (shift_enable) begin
      if (eop) begin
        prev_d = IDLE_LEVEL;
      end else begin
        prev_d = cur_q;
      end
    end
  end

  // Sample and reference registers. Both start at idle so the output is 1 in reset.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      cur_q  <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  // Combinational decode from the two registers, with no extra register stage.
  assign d_orig = ~(cur_q ^ prev_q);

endmodule

// File: tb/tb_nrzi_decode.sv
// Self-checking bench for nrzi_decode. It runs directed scenarios, then random
// stimulus. The reference model follows the NRZI rules directly: the decoded
// bit is 1 when the latest line sample equals the reference level, and 0 otherwise.
module tb_nrzi_decode;

  logic clk = 1'b0;
  logic n_rst;
  logic d_plus;
  logic shift_enable;
  logic eop;
  logic d_orig;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: last sampled line level and current reference level.
  logic m_line;
  logic m_ref;

  nrzi_decode #(
    .IDLE_LEVEL (1'b1),
    .SYNC_STAGES(0)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus      (d_plus),
    .shift_enable(shift_enable),
    .eop         (eop),
    .d_orig      (d_orig)
  );

  always #5 clk = ~clk;

  function automatic logic expected();
    return (m_line == m_ref) ? 1'b1 : 1'b0;
  endfunction

  // Drive one cycle of inputs, let the edge happen, advance the model, and settle 1 ns past the edge.
  task automatic cycle(input logic d, input logic se, input logic e);
    logic old_line;
    d_plus       = d;
    shift_enable = se;
    eop          = e;
    @(posedge clk);
    if (n_rst == 1'b0) begin
      old_line = m_line;
      m_line   = d;
      if (se) m_ref = e ? 1'b1 : old_line;
    end
    #1;
  endtask

  task automatic test_reset();
    n_rst        = 1'b1;
    d_plus       = 1'b0;
    shift_enable = 1'b1;
    eop          = 1'b0;
    m_line       = 1'b1;
    m_ref        = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (d_orig !== 1'b1) begin
        errors++;
        $display("FAIL reset[%0d]: d_orig=%b expected=1", i, d_orig);
      end
      @(posedge clk);
      #1;
    end
    n_rst = 1'b0;
  endtask

  task automatic test_no_transition();
    cycle(1'b1, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL no_trans_pre: d_orig=%b expected=1", d_orig);
    end
    cycle(1'b1, 1'b1, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL no_trans_post: d_orig=%b expected=1", d_orig);
    end
  endtask

  task automatic test_transition_10();
    cycle(1'b0, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL trans10: d_orig=%b expected=0", d_orig);
    end
    cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL trans10_strobe: d_orig=%b expected=1", d_orig);
    end
  endtask

  task automatic test_transition_01();
    cycle(1'b1, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL trans01: d_orig=%b expected=0", d_orig);
    end
    cycle(1'b1, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL trans01_hold: d_orig=%b expected=0", d_orig);
    end
  endtask

  task automatic test_eop_reload();
    cycle(1'b0, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL eop_setup: d_orig=%b expected=1", d_orig);
    end
    cycle(1'b0, 1'b1, 1'b1);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL eop_reload: d_orig=%b expected=0", d_orig);
    end
    cycle(1'b1, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL eop_idle: d_orig=%b expected=1", d_orig);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: d_orig=%b expected=1", d_orig);
    end
    // eop without the strobe must leave the reference (0) untouched.
    cycle(1'b1, 1'b0, 1'b1);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL eop_no_strobe: d_orig=%b expected=0", d_orig);
    end
    cycle(1'b1, 1'b0, 1'b0);
    vectors++;
    if (d_orig !== 1'b0) begin
      errors++;
      $display("FAIL async_pre: d_orig=%b expected=0", d_orig);
    end
    // Assert reset between edges; the output must respond before any clock edge.
    #2;
    d_plus = 1'b0;
    n_rst  = 1'b1;
    m_line = 1'b1;
    m_ref  = 1'b1;
    #1;
    vectors++;
    if (d_orig !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: d_orig=%b expected=1", d_orig);
    end
    @(posedge clk);
    #1;
    n_rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic d;
    for (int i = 0; i < 40; i++) begin
      d = 1'($urandom_range(0, 1));
      cycle(d, 1'b1, (i % 13 == 12) ? 1'b1 : 1'b0);
      vectors++;
      if (d_orig !== expected()) begin
        errors++;
        $display("FAIL back_to_back[%0d]: d_orig=%b expected=%b", i, d_orig, expected());
      end
    end
  endtask

  task automatic test_random();
    logic d, se, e;
    for (int i = 0; i < 400; i++) begin
      d  = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0;
      e  = ($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0;
      cycle(d, se, e);
      vectors++;
      if (d_orig !== expected()) begin
        errors++;
        $display("FAIL random[%0d]: d_plus=%b se=%b eop=%b d_orig=%b expected=%b",
                 i, d, se, e, d_orig, expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_transition();
    test_transition_10();
    test_transition_01();
    test_eop_reload();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
